// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing with trap, mret, redirect and stall.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirect/mret targets into traps.
//
// state | meaning
// BOOT  | first cycle after reset, pc held and not fetchable
// RUN   | fetching; pc advances on trap/mret/redirect/sequential
// HALT  | fetch stopped; waits for resume
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc_out,
  output logic            halted,
  output logic            misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            misalign_q;
  logic [XLEN-1:0] tgt_d;

  // mret outranks redirect, so the epc is the candidate whenever mret is asked for
  always_comb begin
    tgt_d = mret_req ? epc_q : redirect_target;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (trap_req) begin
            pc_q  <= TRAP_VECTOR;
            epc_q <= pc_q;
          end else if (pc_write) begin
            if (halt_req) begin
              state_q <= ST_HALT;
            end else if (mret_req || redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
              if (|(tgt_d & LOW_MASK)) begin
                pc_q       <= TRAP_VECTOR;
                epc_q      <= pc_q;
                misalign_q <= 1'b1;
              end else begin
                pc_q <= tgt_d;
              end
`else
              pc_q <= tgt_d & ~LOW_MASK;
`endif
            end else begin
              pc_q <= pc_plus_inc;
            end
          end
        end
        ST_HALT: if (resume) state_q <= ST_RUN;
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_q + XLEN'(INC);
  assign pc_valid    = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign epc_out     = epc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          INC = 4;

  logic        clk = 1'b0;
  logic        reset, pc_write, redirect_valid, trap_req, mret_req, halt_req, resume;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, pc_plus_inc, epc_out;
  logic        pc_valid, halted, misalign;

  int checks = 0;
  int errors = 0;

  // model: 0 = boot, 1 = run, 2 = halt
  int          m_st;
  logic [31:0] m_pc, m_epc;
  bit          m_mis;

  pc_gen dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .mret_req(mret_req), .halt_req(halt_req), .resume(resume),
    .pc_out(pc_out), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
    .epc_out(epc_out), .halted(halted), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_load(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t % INC != 0) begin
      m_epc = m_pc;
      m_pc  = TV;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
`else
    m_pc = t - (t % INC);
`endif
  endtask

  task automatic compare_all();
    chk("pc_out",      pc_out,            m_pc);
    chk("pc_plus_inc", pc_plus_inc,       m_pc + INC);
    chk("epc_out",     epc_out,           m_epc);
    chk("pc_valid",    {31'd0, pc_valid}, {31'd0, m_st == 1});
    chk("halted",      {31'd0, halted},   {31'd0, m_st == 2});
    chk("misalign",    {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic step(input bit rst_n, input bit pw, input bit rv, input logic [31:0] rt,
                      input bit tr, input bit mr, input bit hr, input bit rs);
    reset = rst_n; pc_write = pw; redirect_valid = rv; redirect_target = rt;
    trap_req = tr; mret_req = mr; halt_req = hr; resume = rs;
    m_mis = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_pc = RV; m_epc = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (tr) begin
        m_epc = m_pc; m_pc = TV;
      end else if (pw) begin
        if (hr)      m_st = 2;
        else if (mr) m_load(m_epc);
        else if (rv) m_load(rt);
        else         m_pc = m_pc + INC;
      end
    end else begin
      if (rs) m_st = 1;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset release into BOOT, then 0, 4, 8
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    chk("boot_pc", pc_out, 32'h0);
    seq(1); chk("seq_4", pc_out, 32'h4);
    seq(1); chk("seq_8", pc_out, 32'h8);
    seq(2); chk("at_10", pc_out, 32'h10);

    // stall with trap in the middle
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("stall_pc", pc_out, 32'h10);
    step(1, 0, 0, 0, 1, 0, 0, 0); chk("trap_pc", pc_out, 32'h100);
    chk("trap_epc", epc_out, 32'h10);
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("trap_hold", pc_out, 32'h100);

    // mret beats redirect
    step(1, 1, 1, 32'h44, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0); chk("epc_44", epc_out, 32'h44);
    step(1, 1, 1, 32'h20, 0, 0, 0, 0); chk("at_20", pc_out, 32'h20);
    step(1, 1, 1, 32'h80, 0, 1, 0, 0); chk("mret_prio", pc_out, 32'h44);

    // wrap, halt, ignore requests in halt, resume
    step(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); chk("at_top", pc_out, 32'hFFFF_FFFC);
    seq(1); chk("wrap", pc_out, 32'h0);
    step(1, 1, 0, 0, 0, 0, 1, 0); chk("halted", {31'd0, halted}, 32'd1);
    step(1, 1, 1, 32'h80, 1, 1, 0, 0); chk("halt_hold", pc_out, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 1); chk("resume_valid", {31'd0, pc_valid}, 32'd1);
    chk("resume_pc", pc_out, 32'h0);

    // trap and halt together: trap wins, stays in RUN
    step(1, 1, 0, 0, 1, 0, 1, 0); chk("trap_halt_pc", pc_out, 32'h100);
    chk("trap_halt_run", {31'd0, halted}, 32'd0);

    // misaligned redirect
    step(1, 1, 1, 32'h30, 0, 0, 0, 0);
    step(1, 1, 1, 32'h42, 0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_epc", epc_out, 32'h30);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
`else
    chk("mis_pc", pc_out, 32'h40);
    chk("mis_pulse", {31'd0, misalign}, 32'd0);
`endif
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("mis_clear", {31'd0, misalign}, 32'd0);

    // reset from HALT with pc_write low
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_rst_pc", pc_out, 32'h0);
    chk("halt_rst_epc", epc_out, 32'h0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_valid", {31'd0, pc_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, t,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
